dma_chan_regbank: RTL and testbench
===================================

Name: dma_chan_regbank

Overview:
- Parametrised successor to the fixed 4-channel, 16-bit DMA address/word-count datapath.
- Holds base and current address and word-count registers for NUM_CH channels.
- CPU programs and reads these registers byte-serially through an internal byte-pointer flip-flop.
- Applies per-transfer address increment/decrement and count decrement, with terminal-count detection and auto-initialize reload. Sits between the CPU data-bus buffer and the DMA control/priority logic.

Parameters:
- NUM_CH, 4, number of DMA channels (≥1).
- DATA_W, 8, CPU data-bus width.
- REG_W, 16, address and word-count register width; must be an integer multiple of DATA_W.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- MasterClear  in  1  software master clear; same effect as Reset.
- ClearPtr  in  1  clears the byte pointer to 0.
- WrEn  in  1  CPU byte write strobe.
- RdEn  in  1  CPU byte read strobe.
- RegSel  in  1  0 = address register, 1 = word-count register.
- ChSel  in  CH_W  CPU-selected channel; CH_W = max(1, $clog2(NUM_CH)).
- DataIn  in  DATA_W  CPU write byte.
- DataOut  out  DATA_W  CPU read byte, registered.
- Step  in  1  one transfer completed on channel StepCh.
- StepCh  in  CH_W  channel being serviced.
- AddrDec  in  NUM_CH  per-channel mode: 1 = decrement address, 0 = increment.
- AutoInit  in  NUM_CH  per-channel auto-initialize enable.
- CurAddr  out  REG_W  current address of StepCh (combinational) to the address buffers.
- TC  out  NUM_CH  terminal-count pulse, one cycle.
- TCStatus  out  NUM_CH  sticky terminal-count flags.
- StatusRd  in  1  clears TCStatus.

Behaviour:
- Reset or MasterClear (synchronous, dominant over all other inputs): every base/current register = 0, byte pointer = 0, DataOut = 0, TC = 0, TCStatus = 0.
- NBYTES = REG_W/DATA_W.
- Byte pointer P (0..NBYTES-1), LSB first:
  - advances on every accepted WrEn or RdEn;
  - wraps from NBYTES-1 to 0;
  - ClearPtr forces 0 and takes precedence over advancing.
- Write, WrEn=1:
  - DataIn goes to byte P of both base and current of register RegSel, channel ChSel;
  - other bytes are unchanged;
  - takes effect next edge.
- Read, RdEn=1 and WrEn=0:
  - DataOut <= byte P of the current register RegSel, channel ChSel; valid the cycle after RdEn (1-cycle latency);
  - DataOut holds its value otherwise.
- WrEn and RdEn together: write performed, read ignored, P advances once.
- ChSel ≥ NUM_CH: writes are ignored, reads return 0, P still advances.
- Step=1 (StepCh < NUM_CH, else ignored), on the next edge for channel c = StepCh:
  - Normal case: curAddr ± 1 mod 2^REG_W, per AddrDec[c]; curCount − 1.
  - curCount == 0 before the step (terminal count):
    - TC[c] pulses high one cycle (the cycle after Step);
    - TCStatus[c] <= 1;
    - if AutoInit[c]=1, curAddr <= baseAddr and curCount <= baseCount;
    - otherwise address updates as in the normal case and count wraps to all-ones.
- Step and CPU write targeting the same channel in the same cycle: the CPU write applies to the written byte; the step is dropped entirely for that channel (no TC).
- StatusRd clears TCStatus; a TC set in the same cycle wins (bit stays 1).
- No other internal state; no multi-cycle operations.

Optional Feature:
- Macro: DMA_ADDR_HOLD_EN.
- Defined:
  - adds port AddrHold in NUM_CH;
  - when AddrHold[c]=1, Step leaves curAddr[c] unchanged, and auto-init does not reload it;
  - the count still decrements or reloads, and TC behaves as normal.
- Undefined: port absent; the address always updates.

Decomposition:
- Package dma_regbank_pkg:
  - typedef enum logic {SEL_ADDR, SEL_COUNT} regsel_t;
  - function nbytes(REG_W, DATA_W);
  - localparam DEF_REG_W = 16, DEF_DATA_W = 8.
- Sub-module dma_chan_regs, one per channel via generate:
  - contains base/current address and count, byte-write logic, step/inc/dec/TC/reload;
  - outputs its current registers and a tc pulse.
- Top level holds the byte pointer, read mux/DataOut register, TCStatus and the CurAddr mux.

Test Plan (NUM_CH=4, DATA_W=8, REG_W=16):
- Reset, then WrEn ch2 SEL_ADDR with 0x34 then 0x12; RdEn twice → DataOut 0x34 then 0x12 (1-cycle latency); P back to 0.
- Program ch1 address 0x00FF, count 0x0001, AddrDec=0; Step ch1 ×2 → address 0x0101; TC[1] pulses on the 2nd step only; count 0xFFFF; TCStatus=0010.
- AutoInit[0]=1, base address 0x8000, count 0x0000; Step ch0 → TC[0] pulse; address reloads 0x8000, count 0x0000; 3 steps with AddrDec=1 → address 0x7FFE after 2 decrements, then reload on TC.
- StatusRd with TCStatus=0010 → 0000; StatusRd concurrent with a ch3 TC → 1000.
- Write ch0 byte 0, then ClearPtr, then write byte again → byte 0 overwritten, high byte untouched; MasterClear mid-sequence → all registers 0, P=0.
- Step ch2 plus WrEn ch2 same cycle → write lands, no address/count change, no TC; with DMA_ADDR_HOLD_EN and AddrHold[2]=1, Step → address unchanged, count decrements.

Source files
------------

// File: rtl/dma_chan_regbank_pkg.sv
// Shared types and sizing helpers for the DMA channel register bank.
package dma_regbank_pkg;

  typedef enum logic {SEL_ADDR, SEL_COUNT} regsel_t;

  localparam int DEF_REG_W  = 16;
  localparam int DEF_DATA_W = 8;

  // Number of CPU bus bytes needed to cover one address/count register.
  function automatic int nbytes(input int reg_w, input int data_w);
    return reg_w / data_w;
  endfunction

endpackage

// File: rtl/dma_chan_regbank_regs.sv
// One DMA channel: base/current address and count, byte-serial CPU write,
// per-transfer step with terminal-count detection and auto-initialize reload.
module dma_chan_regs
  import dma_regbank_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W,
  parameter int PTR_W  = 1
) (
  input  logic              i_clk,
  input  logic              i_clr,
  input  logic              i_wr,
  input  logic              i_reg_sel,
  input  logic [PTR_W-1:0]  i_ptr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_step,
  input  logic              i_addr_dec,
  input  logic              i_auto_init,
  input  logic              i_addr_hold,
  output logic [REG_W-1:0]  o_cur_addr,
  output logic [REG_W-1:0]  o_cur_count,
  output logic              o_tc_hit,
  output logic              o_tc
);

  logic [REG_W-1:0] r_base_addr, r_base_count, r_cur_addr, r_cur_count;
  logic             r_tc;
  logic             w_step;
  logic             w_reload;
  logic [REG_W-1:0] w_next_addr, w_next_count;

  // A CPU write to this channel wins over a transfer step in the same cycle.
  assign w_step   = i_step & ~i_wr;
  assign o_tc_hit = w_step & (r_cur_count == '0);
  assign w_reload = o_tc_hit & i_auto_init;

  always_comb begin
    w_next_addr  = r_cur_addr;
    w_next_count = w_reload ? r_base_count : r_cur_count - REG_W'(1);
    if (!i_addr_hold) begin
      if (w_reload)        w_next_addr = r_base_addr;
      else if (i_addr_dec) w_next_addr = r_cur_addr - REG_W'(1);
      else                 w_next_addr = r_cur_addr + REG_W'(1);
    end
  end

  // NOTE: every register here is plain flop state (not a RAM), so it is all
  // cleared by reset; non-blocking assignments keep the edge semantics exact.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_base_addr  <= '0;
      r_base_count <= '0;
      r_cur_addr   <= '0;
      r_cur_count  <= '0;
      r_tc         <= 1'b0;
    end else begin
      r_tc <= o_tc_hit;
      if (i_wr) begin
        if (regsel_t'(i_reg_sel) == SEL_ADDR) begin
          r_base_addr[i_ptr*DATA_W +: DATA_W] <= i_data;
          r_cur_addr[i_ptr*DATA_W +: DATA_W]  <= i_data;
        end else begin
          r_base_count[i_ptr*DATA_W +: DATA_W] <= i_data;
          r_cur_count[i_ptr*DATA_W +: DATA_W]  <= i_data;
        end
      end else if (w_step) begin
        r_cur_addr  <= w_next_addr;
        r_cur_count <= w_next_count;
      end
    end
  end

  assign o_cur_addr  = r_cur_addr;
  assign o_cur_count = r_cur_count;
  assign o_tc        = r_tc;

endmodule

// File: rtl/dma_chan_regbank.sv
// DMA address/word-count register bank for NUM_CH channels with byte-serial CPU access.
// Optional macro DMA_ADDR_HOLD_EN adds i_addr_hold to freeze per-channel addresses on step.
module dma_chan_regbank
  import dma_regbank_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_master_clear,
  input  logic              i_clear_ptr,
  input  logic              i_wr_en,
  input  logic              i_rd_en,
  input  logic              i_reg_sel,
  input  logic [CH_W-1:0]   i_ch_sel,
  input  logic [DATA_W-1:0] i_data_in,
  output logic [DATA_W-1:0] o_data_out,
  input  logic              i_step,
  input  logic [CH_W-1:0]   i_step_ch,
  input  logic [NUM_CH-1:0] i_addr_dec,
  input  logic [NUM_CH-1:0] i_auto_init,
`ifdef DMA_ADDR_HOLD_EN
  input  logic [NUM_CH-1:0] i_addr_hold,
`endif
  output logic [REG_W-1:0]  o_cur_addr,
  output logic [NUM_CH-1:0] o_tc,
  output logic [NUM_CH-1:0] o_tc_status,
  input  logic              i_status_rd
);

  localparam int NBYTES = nbytes(REG_W, DATA_W);
  localparam int PTR_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

  logic              w_clr;
  logic [PTR_W-1:0]  r_ptr;
  logic [DATA_W-1:0] r_data_out;
  logic [NUM_CH-1:0] r_tc_status;
  logic [NUM_CH-1:0] w_tc_hit;
  logic [NUM_CH-1:0] w_addr_hold;
  logic [REG_W-1:0]  w_cur_addr  [NUM_CH];
  logic [REG_W-1:0]  w_cur_count [NUM_CH];
  logic              w_ch_ok, w_step_ok;
  logic [REG_W-1:0]  w_rd_reg;

  assign w_clr = i_reset | i_master_clear;

`ifdef DMA_ADDR_HOLD_EN
  assign w_addr_hold = i_addr_hold;
`else
  assign w_addr_hold = '0;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    dma_chan_regs #(.DATA_W(DATA_W), .REG_W(REG_W), .PTR_W(PTR_W)) u_regs (
      .i_clk       (i_clk),
      .i_clr       (w_clr),
      .i_wr        (i_wr_en && (i_ch_sel == CH_W'(g))),
      .i_reg_sel   (i_reg_sel),
      .i_ptr       (r_ptr),
      .i_data      (i_data_in),
      .i_step      (i_step && (i_step_ch == CH_W'(g))),
      .i_addr_dec  (i_addr_dec[g]),
      .i_auto_init (i_auto_init[g]),
      .i_addr_hold (w_addr_hold[g]),
      .o_cur_addr  (w_cur_addr[g]),
      .o_cur_count (w_cur_count[g]),
      .o_tc_hit    (w_tc_hit[g]),
      .o_tc        (o_tc[g])
    );
  end

  assign w_ch_ok   = {1'b0, i_ch_sel}  < NUM_CH_L;
  assign w_step_ok = {1'b0, i_step_ch} < NUM_CH_L;

  // Unmapped channels read back as zero.
  always_comb begin
    w_rd_reg = '0;
    if (w_ch_ok) w_rd_reg = i_reg_sel ? w_cur_count[i_ch_sel] : w_cur_addr[i_ch_sel];
  end

  always_ff @(posedge i_clk) begin
    if (w_clr) begin
      r_ptr       <= '0;
      r_data_out  <= '0;
      r_tc_status <= '0;
    end else begin
      if (i_clear_ptr)
        r_ptr <= '0;
      else if (i_wr_en || i_rd_en)
        r_ptr <= (r_ptr == PTR_W'(NBYTES-1)) ? '0 : r_ptr + PTR_W'(1);
      if (i_rd_en && !i_wr_en)
        r_data_out <= w_rd_reg[r_ptr*DATA_W +: DATA_W];
      r_tc_status <= (i_status_rd ? '0 : r_tc_status) | w_tc_hit;
    end
  end

  assign o_cur_addr  = w_step_ok ? w_cur_addr[i_step_ch] : '0;
  assign o_data_out  = r_data_out;
  assign o_tc_status = r_tc_status;

endmodule

// File: tb/tb_dma_chan_regbank.sv
// Directed self-checking bench for dma_chan_regbank (NUM_CH=4, DATA_W=8, REG_W=16).
module tb_dma_chan_regbank;
  import dma_regbank_pkg::*;

  logic       clk = 1'b0;
  logic       reset, master_clear, clear_ptr, wr_en, rd_en, reg_sel, step, status_rd;
  logic [1:0] ch_sel, step_ch;
  logic [7:0] data_in, data_out;
  logic [3:0] addr_dec, auto_init, tc, tc_status;
  logic [15:0] cur_addr;
`ifdef DMA_ADDR_HOLD_EN
  logic [3:0] addr_hold;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dma_chan_regbank #(.NUM_CH(4), .DATA_W(8), .REG_W(16)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_master_clear (master_clear),
    .i_clear_ptr    (clear_ptr),
    .i_wr_en        (wr_en),
    .i_rd_en        (rd_en),
    .i_reg_sel      (reg_sel),
    .i_ch_sel       (ch_sel),
    .i_data_in      (data_in),
    .o_data_out     (data_out),
    .i_step         (step),
    .i_step_ch      (step_ch),
    .i_addr_dec     (addr_dec),
    .i_auto_init    (auto_init),
`ifdef DMA_ADDR_HOLD_EN
    .i_addr_hold    (addr_hold),
`endif
    .o_cur_addr     (cur_addr),
    .o_tc           (tc),
    .o_tc_status    (tc_status),
    .i_status_rd    (status_rd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [1:0] ch, input logic sel, input logic [7:0] d);
    wr_en = 1'b1; ch_sel = ch; reg_sel = sel; data_in = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd_byte(input logic [1:0] ch, input logic sel);
    rd_en = 1'b1; ch_sel = ch; reg_sel = sel;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic do_step(input logic [1:0] ch);
    step = 1'b1; step_ch = ch;
    tick();
    step = 1'b0;
  endtask

  task automatic clr_ptr();
    clear_ptr = 1'b1;
    tick();
    clear_ptr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; master_clear = 1'b0; clear_ptr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    reg_sel = SEL_ADDR; step = 1'b0; status_rd = 1'b0; ch_sel = '0; step_ch = '0;
    data_in = '0; addr_dec = '0; auto_init = '0;
`ifdef DMA_ADDR_HOLD_EN
    addr_hold = '0;
`endif
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("rst_data_out", data_out, 8'h00);
    check("rst_tc", tc, 4'h0);
    check("rst_tc_status", tc_status, 4'h0);
    check("rst_cur_addr", cur_addr, 16'h0000);

    // Byte-serial write and read-back with 1-cycle latency
    wr_byte(2, SEL_ADDR, 8'h34);
    wr_byte(2, SEL_ADDR, 8'h12);
    step_ch = 2; #1;
    check("ch2_addr_comb", cur_addr, 16'h1234);
    rd_byte(2, SEL_ADDR);
    check("rd_lo", data_out, 8'h34);
    rd_byte(2, SEL_ADDR);
    check("rd_hi", data_out, 8'h12);
    tick();
    check("rd_hold", data_out, 8'h12);
    rd_byte(2, SEL_ADDR);
    check("ptr_wrapped", data_out, 8'h34);
    // Simultaneous write/read on byte 1: write lands, read ignored, pointer advances once
    wr_en = 1'b1; rd_en = 1'b1; ch_sel = 2; reg_sel = SEL_ADDR; data_in = 8'h65;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("wr_rd_no_read", data_out, 8'h34);
    check("wr_rd_write", cur_addr, 16'h6534);
    rd_byte(2, SEL_ADDR);
    check("wr_rd_ptr_once", data_out, 8'h34);
    rd_byte(2, SEL_ADDR);
    check("wr_rd_hi", data_out, 8'h65);

    // Channel 1 increment across a byte boundary and terminal count
    wr_byte(1, SEL_ADDR, 8'hFF);
    wr_byte(1, SEL_ADDR, 8'h00);
    wr_byte(1, SEL_COUNT, 8'h01);
    wr_byte(1, SEL_COUNT, 8'h00);
    do_step(1);
    step_ch = 1; #1;
    check("ch1_step1_addr", cur_addr, 16'h0100);
    check("ch1_step1_tc", tc, 4'h0);
    do_step(1);
    step_ch = 1; #1;
    check("ch1_step2_addr", cur_addr, 16'h0101);
    check("ch1_step2_tc", tc, 4'b0010);
    check("ch1_status", tc_status, 4'b0010);
    tick();
    check("ch1_tc_one_cycle", tc, 4'h0);
    rd_byte(1, SEL_COUNT);
    check("ch1_count_lo", data_out, 8'hFF);
    rd_byte(1, SEL_COUNT);
    check("ch1_count_hi", data_out, 8'hFF);

    // Status read clears sticky flags
    status_rd = 1'b1;
    tick();
    status_rd = 1'b0;
    check("status_clear", tc_status, 4'h0);

    // Channel 0 auto-initialize
    auto_init = 4'b0001;
    wr_byte(0, SEL_ADDR, 8'h00);
    wr_byte(0, SEL_ADDR, 8'h80);
    wr_byte(0, SEL_COUNT, 8'h00);
    wr_byte(0, SEL_COUNT, 8'h00);
    do_step(0);
    step_ch = 0; #1;
    check("ch0_ai_tc", tc, 4'b0001);
    check("ch0_ai_addr", cur_addr, 16'h8000);
    check("ch0_ai_status", tc_status, 4'b0001);
    wr_byte(0, SEL_COUNT, 8'h02);
    wr_byte(0, SEL_COUNT, 8'h00);
    addr_dec = 4'b0001;
    do_step(0);
    step_ch = 0; #1;
    check("ch0_dec1", cur_addr, 16'h7FFF);
    do_step(0);
    step_ch = 0; #1;
    check("ch0_dec2", cur_addr, 16'h7FFE);
    check("ch0_dec2_tc", tc, 4'h0);
    do_step(0);
    step_ch = 0; #1;
    check("ch0_reload_tc", tc, 4'b0001);
    check("ch0_reload_addr", cur_addr, 16'h8000);
    rd_byte(0, SEL_COUNT);
    check("ch0_reload_count_lo", data_out, 8'h02);
    rd_byte(0, SEL_COUNT);
    check("ch0_reload_count_hi", data_out, 8'h00);

    // Status read concurrent with a ch3 terminal count: the new flag wins
    status_rd = 1'b1; step = 1'b1; step_ch = 3;
    tick();
    status_rd = 1'b0; step = 1'b0;
    check("status_rd_vs_tc", tc_status, 4'b1000);
    check("ch3_tc", tc, 4'b1000);
    check("ch3_addr", cur_addr, 16'h0001);

    // ClearPtr: rewrite byte 0; ClearPtr with write writes current byte but pointer goes to 0
    wr_byte(0, SEL_ADDR, 8'hAA);
    clr_ptr();
    wr_byte(0, SEL_ADDR, 8'h55);
    step_ch = 0; #1;
    check("clrptr_byte0", cur_addr, 16'h8055);
    clear_ptr = 1'b1;
    wr_byte(0, SEL_ADDR, 8'h11);
    clear_ptr = 1'b0;
    wr_byte(0, SEL_ADDR, 8'h22);
    check("clrptr_precedence", cur_addr, 16'h1122);

    // Step and write to the same channel: write lands, step dropped
    clr_ptr();
    wr_en = 1'b1; ch_sel = 2; reg_sel = SEL_ADDR; data_in = 8'h99;
    step = 1'b1; step_ch = 2;
    tick();
    wr_en = 1'b0; step = 1'b0;
    check("collide_addr", cur_addr, 16'h6599);
    check("collide_no_tc", tc, 4'h0);
    check("collide_status", tc_status, 4'b1000);
    do_step(2);
    check("collide_count_kept", tc, 4'b0100);
    check("ch2_after_step", cur_addr, 16'h659A);

    // Master clear in the middle of a byte sequence
    clr_ptr();
    wr_byte(1, SEL_ADDR, 8'hEE);
    master_clear = 1'b1;
    tick();
    master_clear = 1'b0;
    step_ch = 1; #1;
    check("mclr_addr", cur_addr, 16'h0000);
    check("mclr_status", tc_status, 4'h0);
    check("mclr_data_out", data_out, 8'h00);
    wr_byte(1, SEL_ADDR, 8'h77);
    check("mclr_ptr0", cur_addr, 16'h0077);

`ifdef DMA_ADDR_HOLD_EN
    clr_ptr();
    wr_byte(2, SEL_COUNT, 8'h05);
    wr_byte(2, SEL_COUNT, 8'h00);
    wr_byte(2, SEL_ADDR, 8'h10);
    wr_byte(2, SEL_ADDR, 8'h00);
    addr_hold = 4'b0100;
    do_step(2);
    step_ch = 2; #1;
    check("hold_addr", cur_addr, 16'h0010);
    rd_byte(2, SEL_COUNT);
    check("hold_count", data_out, 8'h04);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
